// File: rtl/fragment_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fragment_writer_pkg
// Description : Shared types for the rasterizer fragment writer: fragment
//               record, writer state encoding, FIFO sizing and the
//               edge-function inside test.
// Revision    : 1.0 - initial release
// ============================================================================
package fragment_writer_pkg;

  localparam int LG_FRAG_FIFO_SZ = 4;

  // One rasterized fragment: pixel position plus the three edge functions.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } fragment_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_TEST   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // A fragment is covered when no edge function is negative; a value of
  // exactly zero lies on the edge and is treated as covered.
  function automatic logic frag_inside(input fragment_t f);
    return ~(f.w0[31] | f.w1[31] | f.w2[31]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fragment_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : fragment_writer_if
// Description : Bundles the fragment FIFO pop handshake and the single-
//               outstanding framebuffer write port.
//   frag_val / frag / pop_frag          : fragment FIFO head and pop strobe
//   mem_req / mem_addr / mem_data / ack : framebuffer write request
//   master modport : fragment writer side
//   slave  modport : FIFO + memory controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface fragment_writer_if
  import fragment_writer_pkg::*;
#(
  parameter int COLOR_W = 32
) ();

  logic               frag_val;
  fragment_t          frag;
  logic               pop_frag;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic               mem_ack;

  modport master (
    input  frag_val,
    input  frag,
    output pop_frag,
    output mem_req,
    output mem_addr,
    output mem_data,
    input  mem_ack
  );

  modport slave (
    output frag_val,
    output frag,
    input  pop_frag,
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    output mem_ack
  );

endinterface
`default_nettype wire

// File: rtl/fragment_writer_fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fragment_writer_fb_addr_gen
// Description : Combinational framebuffer word address:
//               base + y*FB_STRIDE + x, modulo 2^32. Isolated so the
//               multiply can be pipelined or turned into shift-add later.
//   i_fb_base : framebuffer base word address
//   i_x, i_y  : pixel coordinates
//   o_addr    : resulting word address
// Revision    : 1.0 - initial release
// ============================================================================
module fragment_writer_fb_addr_gen #(
  parameter int FB_STRIDE = 640
) (
  input  logic [31:0] i_fb_base,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic [31:0] o_addr
);

  localparam logic [31:0] C_STRIDE = 32'(FB_STRIDE);

  // All operands are 32 bits, so the sum wraps modulo 2^32 naturally.
  assign o_addr = i_fb_base + (i_y * C_STRIDE) + i_x;

endmodule
`default_nettype wire

// File: rtl/fragment_writer.sv
`default_nettype none
// ============================================================================
// Module      : fragment_writer
// Description : Consumer end of the rasterizer fragment FIFO. Pops each
//               fragment, applies the edge-function inside test and writes
//               covered pixels to the framebuffer through a single-
//               outstanding req/ack port. Pulses done once the generator
//               has finished and every fragment has been retired.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_start           : pulse; latches base/colour, clears counters
//   i_fb_base/i_color : framebuffer base address / flat fill colour
//   i_gen_done        : pulse; generator pushed its last fragment
//   io_bus            : FIFO pop handshake + framebuffer write port
//   o_frags_in        : fragments popped since start
//   o_frags_written   : fragments written since start
//   o_busy / o_done   : not idle / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module fragment_writer
  import fragment_writer_pkg::*;
#(
  parameter int FB_STRIDE = 640,
  parameter int COLOR_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [31:0]         i_fb_base,
  input  logic [COLOR_W-1:0]  i_color,
  input  logic                i_gen_done,
  fragment_writer_if.master   io_bus,
  output logic [31:0]         o_frags_in,
  output logic [31:0]         o_frags_written,
  output logic                o_busy,
  output logic                o_done
);

  state_t             r_state;
  state_t             w_state_nxt;
  fragment_t          r_frag;
  logic [31:0]        r_fb_base;
  logic [COLOR_W-1:0] r_color;
  logic               r_gen_seen;
  logic               r_mem_req;
  logic [31:0]        r_mem_addr;
  logic [COLOR_W-1:0] r_mem_data;
  logic [31:0]        r_frags_in;
  logic [31:0]        r_frags_written;

  logic               w_pop;
  logic               w_inside;
  logic               w_ack;
  logic [31:0]        w_addr;

  assign w_inside = frag_inside(r_frag);
  // An ack with no request outstanding carries no meaning and is dropped.
  assign w_ack    = io_bus.mem_ack & r_mem_req;

  fragment_writer_fb_addr_gen #(
    .FB_STRIDE (FB_STRIDE)
  ) u_fb_addr_gen (
    .i_fb_base (r_fb_base),
    .i_x       (r_frag.x),
    .i_y       (r_frag.y),
    .o_addr    (w_addr)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and pop strobe
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A waiting fragment always wins over the finish condition, so a
        // gen_done racing the last fragment cannot drop it.
        if (io_bus.frag_val) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_TEST;
        end else if (r_gen_seen) begin
          w_state_nxt = ST_FINISH;
        end
      end
      ST_TEST: begin
        w_state_nxt = w_inside ? ST_WRITE : ST_FETCH;
      end
      ST_WRITE: begin
        if (w_ack) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath, request port and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frag          <= '0;
      r_fb_base       <= '0;
      r_color         <= '0;
      r_gen_seen      <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_data      <= '0;
      r_frags_in      <= '0;
      r_frags_written <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (i_start) begin
          r_fb_base       <= i_fb_base;
          r_color         <= i_color;
          r_frags_in      <= '0;
          r_frags_written <= '0;
          // gen_done coincident with start still counts for this triangle.
          r_gen_seen      <= i_gen_done;
        end
      end else if (i_gen_done) begin
        r_gen_seen <= 1'b1;
      end

      if (w_pop) begin
        r_frag     <= io_bus.frag;
        r_frags_in <= r_frags_in + 32'd1;
      end

      // Address and data are captured once and then held for the whole
      // request, so the memory side sees a stable transaction.
      if ((r_state == ST_TEST) && w_inside) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_addr;
        r_mem_data <= r_color;
      end

      if ((r_state == ST_WRITE) && w_ack) begin
        r_mem_req       <= 1'b0;
        r_frags_written <= r_frags_written + 32'd1;
      end
    end
  end

  assign io_bus.pop_frag = w_pop;
  assign io_bus.mem_req  = r_mem_req;
  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.mem_data = r_mem_data;

  assign o_frags_in      = r_frags_in;
  assign o_frags_written = r_frags_written;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_fragment_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fragment_writer
// Description : Self-checking bench for fragment_writer. Models the fragment
//               FIFO and the memory controller, applies a table of single-
//               fragment vectors and hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fragment_writer;
  import fragment_writer_pkg::*;

  localparam int COLOR_W = 32;

  typedef struct {
    logic [31:0] base;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic        exp_in;
    logic [31:0] exp_addr;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic [31:0]        i_fb_base;
  logic [COLOR_W-1:0] i_color;
  logic               i_gen_done;
  logic [31:0]        o_frags_in;
  logic [31:0]        o_frags_written;
  logic               o_busy;
  logic               o_done;

  fragment_writer_if #(.COLOR_W(COLOR_W)) bus ();

  fragment_writer #(
    .FB_STRIDE (640),
    .COLOR_W   (COLOR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_fb_base       (i_fb_base),
    .i_color         (i_color),
    .i_gen_done      (i_gen_done),
    .io_bus          (bus),
    .o_frags_in      (o_frags_in),
    .o_frags_written (o_frags_written),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ack_lat  = 0;
  int          req_age  = 0;
  int          done_cnt = 0;
  fragment_t   fifo[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          pop_cyc[$];
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic fragment_t mk(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] w2);
    fragment_t f;
    f.x = x; f.y = y; f.w0 = w0; f.w1 = w1; f.w2 = w2;
    return f;
  endfunction

  task automatic drive_fifo();
    bus.frag_val = (fifo.size() != 0);
    bus.frag     = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // One clock: sample DUT outputs before the edge, advance, then update the
  // FIFO and memory models 1 ns after the edge.
  task automatic step();
    logic               p, rq, ak, bad;
    logic [31:0]        ad;
    logic [COLOR_W-1:0] dt;
    p   = bus.pop_frag;
    rq  = bus.mem_req;
    ak  = bus.mem_ack;
    ad  = bus.mem_addr;
    dt  = bus.mem_data;
    bad = p & (~bus.frag_val | rq | ~o_busy);
    chk("pop_legal", 32'(bad), 32'd0);
    if (rq && ak) begin
      wr_addr_q.push_back(ad);
      wr_data_q.push_back(dt);
    end
    if (p) pop_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    i_start    = 1'b0;
    i_gen_done = 1'b0;
    if (p && fifo.size() != 0) void'(fifo.pop_front());
    drive_fifo();
    if (rq && !ak && rst_n) begin
      chk("req_held", 32'(bus.mem_req), 32'd1);
      chk("addr_stable", bus.mem_addr, ad);
      chk("data_stable", bus.mem_data, dt);
    end
    if (bus.mem_req) begin
      bus.mem_ack = (req_age >= ack_lat);
      req_age++;
    end else begin
      bus.mem_ack = 1'b0;
      req_age     = 0;
    end
    if (o_done) done_cnt++;
  endtask

  task automatic wait_done(input int bound, input string name);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      if (o_done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      step();
      chk({name, "_done_1cyc"}, 32'(o_done), 32'd0);
      chk({name, "_idle"}, 32'(o_busy), 32'd0);
      chk({name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] col);
    i_fb_base = base;
    i_color   = col;
    i_start   = 1'b1;
    step();
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic [31:0] col;
    v   = vecs[idx];
    col = 32'hC0DE_0000 | 32'(idx);
    wr_addr_q.delete();
    wr_data_q.delete();
    fifo.delete();
    fifo.push_back(mk(v.x, v.y, v.w0, v.w1, v.w2));
    drive_fifo();
    step();
    chk("idle_no_pop", 32'(bus.pop_frag), 32'd0);
    ack_lat = 1;
    do_start(v.base, col);
    for (int i = 0; i < 8; i++) step();
    i_gen_done = 1'b1;
    wait_done(40, "vec");
    chk("vec_frags_in", o_frags_in, 32'd1);
    chk("vec_frags_written", o_frags_written, 32'(v.exp_in));
    chk("vec_nwrites", 32'(wr_addr_q.size()), 32'(v.exp_in));
    if (v.exp_in && wr_addr_q.size() == 1) begin
      chk("vec_addr", wr_addr_q[0], v.exp_addr);
      chk("vec_data", wr_data_q[0], col);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // base, x, y, w0, w1, w2, inside, address (stride 640)
    vecs[0] = '{32'h1000, 3, 2, 5, 7, 1, 1'b1, 32'h1503};           // 2*640 = 0x500
    vecs[1] = '{32'h0, 0, 0, 5, 32'hFFFF_FFFF, 3, 1'b0, 32'h0};    // w1 = -1
    vecs[2] = '{32'h100, 10, 0, 0, 0, 0, 1'b1, 32'h10A};           // all on edge
    vecs[3] = '{32'h0, 0, 0, 32'h8000_0000, 1, 1, 1'b0, 32'h0};    // most negative w0
    vecs[4] = '{32'h2000, 639, 1, 1, 1, 32'h7FFF_FFFF, 1'b1, 32'h24FF};
    vecs[5] = '{32'hFFFF_FFF0, 32'h20, 0, 1, 1, 1, 1'b1, 32'h10};   // base wraps
    vecs[6] = '{32'h0, 1, 32'h0100_0000, 1, 1, 1, 1'b1, 32'h8000_0001}; // y*640 wraps
    vecs[7] = '{32'h0, 0, 0, 1, 1, 32'hFFFF_FFFF, 1'b0, 32'h0};    // w2 = -1

    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_gen_done   = 1'b0;
    i_fb_base    = '0;
    i_color      = '0;
    bus.frag_val = 1'b0;
    bus.frag     = '0;
    bus.mem_ack  = 1'b0;
    #12;
    chk("rst_pop", 32'(bus.pop_frag), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_data", bus.mem_data, 32'd0);
    chk("rst_frags_in", o_frags_in, 32'd0);
    chk("rst_frags_written", o_frags_written, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- table-driven single fragments ----
    for (int i = 0; i < 8; i++) run_vec(i);

    // ---- back-pressure: 8 covered fragments, ack after 10 idle cycles ----
    wr_addr_q.delete();
    wr_data_q.delete();
    fifo.delete();
    for (int i = 0; i < 8; i++) fifo.push_back(mk(32'(i), 32'(i), 1, 1, 1));
    drive_fifo();
    ack_lat = 10;
    do_start(32'h4000, 32'hAABB_CCDD);
    i_gen_done = 1'b1;
    wait_done(300, "bp");
    chk("bp_frags_in", o_frags_in, 32'd8);
    chk("bp_frags_written", o_frags_written, 32'd8);
    chk("bp_nwrites", 32'(wr_addr_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      chk("bp_addr", wr_addr_q[i], 32'h4000 + 32'(i) * 32'd641);
      chk("bp_data", wr_data_q[i], 32'hAABB_CCDD);
    end

    // ---- throughput: covered every 3 cycles, rejected every 2 ----
    pop_cyc.delete();
    fifo.delete();
    for (int i = 0; i < 3; i++) fifo.push_back(mk(32'(i), 0, 1, 1, 1));
    for (int i = 0; i < 3; i++) fifo.push_back(mk(32'(i), 0, 32'hFFFF_FFFE, 1, 1));
    drive_fifo();
    ack_lat = 0;
    do_start(32'h0, 32'h1);
    i_gen_done = 1'b1;
    wait_done(60, "thr");
    chk("thr_npops", 32'(pop_cyc.size()), 32'd6);
    if (pop_cyc.size() == 6) begin
      chk("thr_cov_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
      chk("thr_cov_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd3);
      chk("thr_rej_gap0", 32'(pop_cyc[4] - pop_cyc[3]), 32'd2);
      chk("thr_rej_gap1", 32'(pop_cyc[5] - pop_cyc[4]), 32'd2);
    end
    chk("thr_frags_written", o_frags_written, 32'd3);

    // ---- gen_done while in WRITE with two fragments still queued ----
    wr_addr_q.delete();
    fifo.delete();
    for (int i = 0; i < 3; i++) fifo.push_back(mk(32'(i), 0, 1, 1, 1));
    drive_fifo();
    ack_lat = 5;
    do_start(32'h0, 32'h5);
    for (int i = 0; i < 20 && !bus.mem_req; i++) step();
    chk("gd_req_seen", 32'(bus.mem_req), 32'd1);
    chk("gd_queued", 32'(fifo.size()), 32'd2);
    i_gen_done = 1'b1;
    step();
    chk("gd_no_early_done", 32'(o_done), 32'd0);
    wait_done(100, "gd");
    chk("gd_frags_written", o_frags_written, 32'd3);
    chk("gd_nwrites", 32'(wr_addr_q.size()), 32'd3);

    // ---- gen_done on the start cycle with the FIFO empty ----
    fifo.delete();
    drive_fifo();
    i_gen_done = 1'b1;
    do_start(32'h0, 32'h0);
    chk("sg_fetch_busy", 32'(o_busy), 32'd1);
    chk("sg_fetch_nodone", 32'(o_done), 32'd0);
    chk("sg_frags_in", o_frags_in, 32'd0);
    step();
    chk("sg_done", 32'(o_done), 32'd1);
    step();
    chk("sg_done_1cyc", 32'(o_done), 32'd0);
    chk("sg_idle", 32'(o_busy), 32'd0);

    // ---- asynchronous reset in the middle of a write ----
    fifo.delete();
    fifo.push_back(mk(1, 1, 1, 1, 1));
    drive_fifo();
    ack_lat = 1000;
    do_start(32'h0, 32'h9);
    for (int i = 0; i < 20 && !bus.mem_req; i++) step();
    chk("ar_req_seen", 32'(bus.mem_req), 32'd1);
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.mem_req), 32'd0);
    chk("ar_frags_in", o_frags_in, 32'd0);
    chk("ar_frags_written", o_frags_written, 32'd0);
    chk("ar_busy", 32'(o_busy), 32'd0);
    chk("ar_addr", bus.mem_addr, 32'd0);
    #2;
    rst_n = 1'b1;
    fifo.delete();
    drive_fifo();
    bus.mem_ack = 1'b0;
    req_age     = 0;
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
